// File: rtl/pc_seq_pkg.sv
// Shared opcode/state encodings and field positions for the PC sequencer.
package pc_seq_pkg;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_JMP   = 4'h7,
        OP_JMPZ  = 4'h8,
        OP_JMPC  = 4'h9,
        OP_CALL  = 4'hA,
        OP_RET   = 4'hB,
        OP_UND_C = 4'hC,
        OP_UND_D = 4'hD,
        OP_UND_E = 4'hE,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_LOAD) && (op <= OP_OR);
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return (op >= OP_JMP) && (op <= OP_RET);
    endfunction

endpackage

// File: rtl/pc_seq_decode.sv
// Combinational opcode classifier: datapath op, branch kind, halt, undefined.
module pc_seq_decode
    import pc_seq_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       alu,
    output logic       jmp,
    output logic       jmpz,
    output logic       jmpc,
    output logic       call,
    output logic       ret,
    output logic       halt,
    output logic       illegal
);

    always_comb begin
        alu     = is_alu_op(opcode);
        jmp     = 1'b0;
        jmpz    = 1'b0;
        jmpc    = 1'b0;
        call    = 1'b0;
        ret     = 1'b0;
        halt    = 1'b0;
        illegal = 1'b0;
        if (is_branch(opcode)) begin
            case (opcode)
                OP_JMP:  jmp  = 1'b1;
                OP_JMPZ: jmpz = 1'b1;
                OP_JMPC: jmpc = 1'b1;
                OP_CALL: call = 1'b1;
                OP_RET:  ret  = 1'b1;
                default: ;
            endcase
        end
        case (opcode)
            OP_HALT:                    halt    = 1'b1;
            OP_UND_C, OP_UND_D, OP_UND_E: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute control FSM driving PC commands and the datapath handshake.
// Optional single-step input enabled by defining SEQ_STEP_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int IW      = 16,
    parameter int AW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
`ifdef SEQ_STEP_EN
    input  logic          step,
`endif
    input  logic [IW-1:0] mem_rdata,
    input  logic          flag_z,
    input  logic          flag_c,
    input  logic          exe_done,
    output logic          pc_inc,
    output logic          pc_jmp,
    output logic          pc_call,
    output logic          pc_ret,
    output logic [AW-1:0] pc_addr,
    output logic [IW-1:0] ir,
    output logic          exe_valid,
    output logic          halted,
    output logic          illegal
);

    localparam logic [2:0] S_IDLE   = 3'(IDLE);
    localparam logic [2:0] S_FETCH  = 3'(FETCH);
    localparam logic [2:0] S_DECODE = 3'(DECODE);
    localparam logic [2:0] S_EXEC   = 3'(EXEC);
    localparam logic [2:0] S_HALT   = 3'(HALT);
    localparam logic [1:0] LAST_CNT = 2'(MEM_LAT - 1);

    logic [2:0] state, state_nxt;
    logic [1:0] fetch_cnt;
    logic       fetch_last;
    logic       one_shot;
    logic       step_go;
    logic       cont;
    logic       d_alu, d_jmp, d_jmpz, d_jmpc, d_call, d_ret, d_halt, d_ill;

`ifdef SEQ_STEP_EN
    assign step_go = step;
`else
    assign step_go = 1'b0;
`endif

    pc_seq_decode u_dec (
        .opcode  (ir[OPC_MSB:OPC_LSB]),
        .alu     (d_alu),
        .jmp     (d_jmp),
        .jmpz    (d_jmpz),
        .jmpc    (d_jmpc),
        .call    (d_call),
        .ret     (d_ret),
        .halt    (d_halt),
        .illegal (d_ill)
    );

    assign fetch_last = (fetch_cnt == LAST_CNT);
    // A stepped instruction always falls back to IDLE, whatever run does meanwhile.
    assign cont       = run & ~one_shot;
    assign exe_valid  = (state == S_EXEC);
    assign halted     = (state == S_HALT);

    always_comb begin
        state_nxt = state;
        pc_inc    = 1'b0;
        pc_jmp    = 1'b0;
        pc_call   = 1'b0;
        pc_ret    = 1'b0;
        pc_addr   = '0;
        case (state)
            S_IDLE:  if (run || step_go) state_nxt = S_FETCH;
            S_FETCH: if (fetch_last)     state_nxt = S_DECODE;
            S_DECODE: begin
                if (d_halt) begin
                    state_nxt = S_HALT;
                end else if (d_alu) begin
                    state_nxt = S_EXEC;
                end else begin
                    state_nxt = cont ? S_FETCH : S_IDLE;
                    if (d_jmp || (d_jmpz && flag_z) || (d_jmpc && flag_c)) begin
                        pc_jmp  = 1'b1;
                        pc_addr = ir[AW-1:0];
                    end else if (d_call) begin
                        pc_call = 1'b1;
                        pc_addr = ir[AW-1:0];
                    end else if (d_ret) begin
                        pc_ret  = 1'b1;
                    end else begin
                        pc_inc  = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (exe_done) begin
                    pc_inc    = 1'b1;
                    state_nxt = cont ? S_FETCH : S_IDLE;
                end
            end
            S_HALT:  ;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ir        <= '0;
            fetch_cnt <= '0;
            illegal   <= 1'b0;
            one_shot  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH)
                fetch_cnt <= fetch_last ? 2'd0 : fetch_cnt + 2'd1;
            else
                fetch_cnt <= 2'd0;
            if (state == S_FETCH && fetch_last)
                ir <= mem_rdata;
            if (state == S_DECODE && d_ill)
                illegal <= 1'b1;
            if (state == S_IDLE && state_nxt == S_FETCH)
                one_shot <= step_go & ~run;
            else if (state_nxt == S_IDLE)
                one_shot <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: instruction-level model with a behavioural PC/stack and memory.
module tb_pc_sequencer;

    localparam int L = 2;

    logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0, step = 1'b0;
    logic        flag_z = 1'b0, flag_c = 1'b0, exe_done = 1'b0;
    logic [15:0] mem_rdata, ir;
    logic        pc_inc, pc_jmp, pc_call, pc_ret, exe_valid, halted, illegal;
    logic [7:0]  pc_addr;

    logic [15:0] mem [256];
    logic [7:0]  mpc = 8'h0;
    logic [7:0]  stk [$];
    logic        m_ill = 1'b0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;
    assign mem_rdata = mem[mpc];

    pc_sequencer #(.IW(16), .AW(8), .MEM_LAT(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
`ifdef SEQ_STEP_EN
        .step      (step),
`endif
        .mem_rdata (mem_rdata),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .exe_done  (exe_done),
        .pc_inc    (pc_inc),
        .pc_jmp    (pc_jmp),
        .pc_call   (pc_call),
        .pc_ret    (pc_ret),
        .pc_addr   (pc_addr),
        .ir        (ir),
        .exe_valid (exe_valid),
        .halted    (halted),
        .illegal   (illegal)
    );

    function automatic logic [14:0] obs();
        return {pc_inc, pc_jmp, pc_call, pc_ret, pc_addr, exe_valid, halted, illegal};
    endfunction

    // cmd bits: {inc, jmp, call, ret}
    function automatic logic [14:0] mk(input logic [3:0] cmd, input logic [7:0] a,
                                       input logic ev, input logic h, input logic ill);
        return {cmd, a, ev, h, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic d, input logic rst,
                       input logic [14:0] exp, input string tag);
        @(posedge clk);
        #1;
        run = r; step = s; exe_done = d; rst_n = ~rst;
        @(negedge clk);
        chk(tag, 32'(obs()), 32'(exp));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; run = 1'b0; step = 1'b0; exe_done = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out", 32'(obs()), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        m_ill = 1'b0; mpc = 8'h0; stk.delete();
    endtask

    task automatic idle(input int n, input logic go_run, input logic go_step);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 1'($urandom % 2), 1'b0, mk(4'b0, 8'h0, 1'b0, 1'b0, m_ill), "idle");
        cyc(go_run, go_step, 1'($urandom % 2), 1'b0, mk(4'b0, 8'h0, 1'b0, 1'b0, m_ill), "idle_go");
    endtask

    // One instruction from the first FETCH cycle through its command/completion cycle.
    task automatic do_instr(input logic fz, input logic fc, input int w, input logic nrun,
                            input logic rr, input int abort_k);
        logic [15:0] ins;
        logic [3:0]  op, cmd;
        logic [7:0]  t, a, npc;
        logic        alu, r, d;
        int          c;
        ins = mem[mpc];
        op  = ins[15:12];
        t   = ins[7:0];
        alu = (op >= 4'h1) && (op <= 4'h6);
        c   = alu ? L + 2 + w : L + 1;
        npc = mpc + 8'h1;
        a   = 8'h0;
        cmd = 4'b1000;
        case (op)
            4'h7: begin cmd = 4'b0100; a = t; npc = t; end
            4'h8: if (fz) begin cmd = 4'b0100; a = t; npc = t; end
            4'h9: if (fc) begin cmd = 4'b0100; a = t; npc = t; end
            4'hA: begin cmd = 4'b0010; a = t; npc = t; stk.push_back(mpc + 8'h1); end
            4'hB: begin cmd = 4'b0001; npc = (stk.size() > 0) ? stk.pop_back() : 8'h0; end
            4'hF: cmd = 4'b0000;
            default: ;
        endcase
        flag_z = fz;
        flag_c = fc;
        for (int k = 1; k <= c; k++) begin
            r = (k == c) ? nrun : (rr ? 1'($urandom % 2) : 1'b0);
            if (alu && k >= L + 2) d = (k == c);
            else d = 1'($urandom % 2);
            cyc(r, 1'b0, d, (k == abort_k),
                mk((k == c) ? cmd : 4'b0, (k == c) ? a : 8'h0, alu && (k >= L + 2), 1'b0, m_ill),
                $sformatf("op%h_k%0d", op, k));
            if (k == abort_k) return;
        end
        chk($sformatf("ir_op%h", op), 32'(ir), 32'(ins));
        if (op >= 4'hC && op <= 4'hE) m_ill = 1'b1;
        mpc = npc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic nr;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h0000;  mem[8'h01] = 16'h7042;
        mem[8'h42] = 16'h8010;  mem[8'h43] = 16'h8010;
        mem[8'h10] = 16'h9020;  mem[8'h11] = 16'h9020;
        mem[8'h20] = 16'h3000;  mem[8'h21] = 16'h3000;
        mem[8'h22] = 16'hA030;  mem[8'h30] = 16'hB000;
        mem[8'h23] = 16'hC000;  mem[8'h24] = 16'h1F00;
        mem[8'h25] = 16'hF000;

        do_reset();
        idle(1, 1'b1, 1'b0);
        do_instr(1'b0, 1'b0, 0, 1'b1, 1'b1, 0);   // NOP
        do_instr(1'b0, 1'b0, 0, 1'b1, 1'b1, 0);   // JMP 42
        do_instr(1'b0, 1'b1, 0, 1'b1, 1'b1, 0);   // JMPZ, z=0
        do_instr(1'b1, 1'b0, 0, 1'b1, 1'b1, 0);   // JMPZ, z=1
        do_instr(1'b1, 1'b0, 0, 1'b1, 1'b1, 0);   // JMPC, c=0
        do_instr(1'b0, 1'b1, 0, 1'b1, 1'b1, 0);   // JMPC, c=1
        do_instr(1'b0, 1'b0, 2, 1'b1, 1'b1, 0);   // ADD, 3 EXEC cycles
        do_instr(1'b0, 1'b0, 0, 1'b1, 1'b1, 0);   // ADD, done in first cycle
        do_instr(1'b0, 1'b0, 0, 1'b1, 1'b1, 0);   // CALL 30
        do_instr(1'b0, 1'b0, 0, 1'b1, 1'b1, 0);   // RET
        do_instr(1'b0, 1'b0, 0, 1'b0, 1'b1, 0);   // undefined C, stop
        idle(3, 1'b1, 1'b0);
        do_instr(1'b0, 1'b0, 1, 1'b0, 1'b1, 0);   // LOAD, stop
        idle(0, 1'b1, 1'b0);
        do_instr(1'b0, 1'b0, 0, 1'b1, 1'b1, 0);   // HALT
        for (int i = 0; i < 6; i++)
            cyc(1'($urandom % 2), 1'b0, 1'($urandom % 2), 1'b0,
                mk(4'b0, 8'h0, 1'b0, 1'b1, m_ill), "halt");

        // Reset in the middle of a datapath op, with illegal already set.
        mem[8'h00] = 16'hC000;
        mem[8'h01] = 16'h3000;
        do_reset();
        idle(0, 1'b1, 1'b0);
        do_instr(1'b0, 1'b0, 0, 1'b1, 1'b1, 0);
        do_instr(1'b0, 1'b0, 5, 1'b1, 1'b1, L + 3);
        m_ill = 1'b0; mpc = 8'h0; stk.delete();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, mk(4'b0, 8'h0, 1'b0, 1'b0, 1'b0), "rst_exec");
        chk("rst_exec_ir", 32'(ir), 32'd0);

`ifdef SEQ_STEP_EN
        idle(2, 1'b0, 1'b1);
        do_instr(1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
        idle(4, 1'b0, 1'b1);
        do_instr(1'b0, 1'b0, 1, 1'b0, 1'b0, 0);
        idle(4, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            if (mem[i][15:12] == 4'hF) mem[i][15:12] = 4'h0;
        end
        idle(1, 1'b1, 1'b0);
        for (int n = 0; n < 250; n++) begin
            nr = ($urandom % 6) != 0;
            do_instr(1'($urandom % 2), 1'($urandom % 2), int'($urandom % 4), nr, 1'b1, 0);
            if (!nr) idle(int'($urandom % 3), 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
